// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory round-robin arbiter: default widths
// and the helper that locates a core's lane inside a packed per-core bus.
package dm_arb_pkg;

    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 16;

    function automatic int lane_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr,
// wrapping modulo NUM_CORES.
module rr_pick #(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = 2
) (
    input  logic [NUM_CORES-1:0] elig,
    input  logic [ID_W-1:0]      rr_ptr,
    output logic [ID_W-1:0]      winner,
    output logic                 any_valid
);

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NUM_CORES;
            if (!any_valid && elig[idx]) begin
                winner    = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dm_rr_arbiter.sv
// Shares one synchronous single-port data memory among NUM_CORES cores with
// round-robin arbitration, registered grant/memory drive and 2-cycle read return.
module dm_rr_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_en,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_we,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [NUM_CORES-1:0] elig;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      ptr_next;
    logic                 any_valid;
    logic                 win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    logic                 s1_valid;
    logic                 s1_read;
    logic [ID_W-1:0]      s1_id;

    // The ~gnt term keeps a core that is dropping req from winning twice.
    assign elig = req & core_en & ~gnt;

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .ID_W      (ID_W)
    ) u_pick (
        .elig      (elig),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (ID_W'(i) == winner) begin
                win_we    = we[i];
                win_addr  = addr[lane_lsb(i, ADDR_W) +: ADDR_W];
                win_wdata = wdata[lane_lsb(i, DATA_W) +: DATA_W];
            end
        end
    end

    assign ptr_next = (int'(winner) == NUM_CORES - 1) ? '0 : winner + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            s1_valid  <= 1'b0;
            s1_read   <= 1'b0;
            s1_id     <= '0;
            busy      <= 1'b0;
        end else begin
            if (any_valid) begin
                rr_ptr    <= ptr_next;
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end
            gnt      <= any_valid ? (NUM_CORES'(1) << winner) : '0;
            mem_we   <= any_valid & win_we;
            s1_valid <= any_valid;
            s1_read  <= any_valid & ~win_we;
            s1_id    <= winner;
            // Stage 2: RAM data for a stage-1 read appears in this cycle.
            rvalid   <= (s1_valid && s1_read) ? (NUM_CORES'(1) << s1_id) : '0;
            busy     <= any_valid | s1_valid;
        end
    end

    assign rdata = mem_rdata;

endmodule
